// File: rtl/csr_access_unit_if.sv
// Bundles the request, response and CSR-file signals of the CSR access unit.
// "master" is the execute stage plus CSR file; "slave" is the access unit itself.
interface csr_access_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_address;
  logic [4:0]      req_rs1_field;
  logic [XLEN-1:0] req_rs1_value;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rd_value;
  logic            resp_illegal;
  logic [11:0]     csr_address;
  logic [XLEN-1:0] csr_read_value;
  logic [XLEN-1:0] csr_write_value;
  logic            csr_write_enable;

  modport master (
    output req_valid, req_funct3, req_address, req_rs1_field, req_rs1_value,
    input  req_ready,
    input  resp_valid, resp_rd_value, resp_illegal,
    output resp_ready,
    input  csr_address, csr_write_value, csr_write_enable,
    output csr_read_value
  );

  modport slave (
    input  req_valid, req_funct3, req_address, req_rs1_field, req_rs1_value,
    output req_ready,
    output resp_valid, resp_rd_value, resp_illegal,
    input  resp_ready,
    output csr_address, csr_write_value, csr_write_enable,
    input  csr_read_value
  );
endinterface

// File: rtl/csr_access_unit.sv
// Machine-mode Zicsr initiator: sequences read, modify and write against a CSR file
// with combinational read and posedge write, returning the old value or an illegal flag.
module csr_access_unit #(
  parameter int unsigned XLEN              = 32,
  parameter bit          ENFORCE_READ_ONLY = 1'b1
) (
  input logic               clock,
  input logic               reset_n,
  csr_access_unit_if.slave  bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRead    = 2'd1;
  localparam logic [1:0] StWrite   = 2'd2;
  localparam logic [1:0] StRespond = 2'd3;

  logic [1:0]      state_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rs1_field_q;
  logic [XLEN-1:0] rs1_value_q;
  logic [11:0]     csr_address_q;
  logic [XLEN-1:0] write_value_q;
  logic [XLEN-1:0] rd_value_q;
  logic            illegal_q;

  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_value;
  logic            write_intent;
  logic            illegal;

  always_comb begin
    operand = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_field_q} : rs1_value_q;

    new_value = operand;
    case (funct3_q[1:0])
      2'b10:   new_value = bus.csr_read_value | operand;
      2'b11:   new_value = bus.csr_read_value & ~operand;
      default: new_value = operand;
    endcase

    // Set/clear with x0 or a zero uimm must not write, so read-only CSRs stay readable.
    write_intent = (funct3_q[1:0] == 2'b01) || (rs1_field_q != 5'd0);
    illegal      = (funct3_q[1:0] == 2'b00) ||
                   (ENFORCE_READ_ONLY && write_intent && (csr_address_q[11:10] == 2'b11));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      funct3_q      <= 3'd0;
      rs1_field_q   <= 5'd0;
      rs1_value_q   <= '0;
      csr_address_q <= 12'd0;
      write_value_q <= '0;
      rd_value_q    <= '0;
      illegal_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            funct3_q      <= bus.req_funct3;
            rs1_field_q   <= bus.req_rs1_field;
            rs1_value_q   <= bus.req_rs1_value;
            csr_address_q <= bus.req_address;
            state_q       <= StRead;
          end
        end
        StRead: begin
          write_value_q <= new_value;
          if (illegal) begin
            rd_value_q <= '0;
            illegal_q  <= 1'b1;
            state_q    <= StRespond;
          end else begin
            rd_value_q <= bus.csr_read_value;
            state_q    <= write_intent ? StWrite : StRespond;
          end
        end
        StWrite: begin
          state_q <= StRespond;
        end
        StRespond: begin
          if (bus.resp_ready) begin
            illegal_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready        = (state_q == StIdle);
  assign bus.resp_valid       = (state_q == StRespond);
  assign bus.resp_rd_value    = rd_value_q;
  assign bus.resp_illegal     = illegal_q;
  assign bus.csr_address      = csr_address_q;
  assign bus.csr_write_value  = write_value_q;
  assign bus.csr_write_enable = (state_q == StWrite);

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: directed Zicsr vectors against a CSR file model.
module tb_csr_access_unit;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        ill;
    int          lat;
    int          writes;
    logic [31:0] wdata;
    logic [11:0] addr;
  } exp_t;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   wcount;
  int   total_writes;
  bit   seen;
  logic [31:0] wdata_seen;
  logic [11:0] waddr_seen;
  logic [31:0] csr_mem [0:4095];
  exp_t sb [$];

  csr_access_unit_if #(.XLEN(32)) bus ();

  csr_access_unit #(
    .XLEN              (32),
    .ENFORCE_READ_ONLY (1'b1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.csr_read_value = csr_mem[bus.csr_address];

  always @(posedge clock) begin
    if (bus.csr_write_enable) csr_mem[bus.csr_address] <= bus.csr_write_value;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endfunction

  function automatic exp_t mk(input string name, input logic [31:0] rd, input logic ill,
                              input int lat, input int writes, input logic [31:0] wdata,
                              input logic [11:0] addr);
    exp_t e;
    e.name = name; e.rd = rd; e.ill = ill; e.lat = lat;
    e.writes = writes; e.wdata = wdata; e.addr = addr;
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      seen   = 1'b0;
      wcount = 0;
      cyc    = 0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        cyc    = 0;
        wcount = 0;
        seen   = 1'b0;
      end else begin
        cyc++;
      end
      if (bus.csr_write_enable) begin
        wcount++;
        total_writes++;
        wdata_seen = bus.csr_write_value;
        waddr_seen = bus.csr_address;
      end
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'd1, 32'd0);
        end else begin
          if (!seen) begin
            check({sb[0].name, "_latency"}, cyc, sb[0].lat);
            seen = 1'b1;
          end
          check({sb[0].name, "_rd"}, bus.resp_rd_value, sb[0].rd);
          check({sb[0].name, "_illegal"}, {31'd0, bus.resp_illegal}, {31'd0, sb[0].ill});
          check({sb[0].name, "_req_ready"}, {31'd0, bus.req_ready}, 32'd0);
          if (bus.resp_ready) begin
            check({sb[0].name, "_writes"}, wcount, sb[0].writes);
            if (sb[0].writes != 0) begin
              check({sb[0].name, "_wdata"}, wdata_seen, sb[0].wdata);
              check({sb[0].name, "_waddr"}, {20'd0, waddr_seen}, {20'd0, sb[0].addr});
            end
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] fld,
                       input logic [31:0] v, input bit push, input exp_t e);
    int t = 0;
    while (!bus.req_ready && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    if (!bus.req_ready) begin
      check("issue_timeout", 32'd0, 32'd1);
    end else begin
      if (push) sb.push_back(e);
      bus.req_valid     = 1'b1;
      bus.req_funct3    = f3;
      bus.req_address   = a;
      bus.req_rs1_field = fld;
      bus.req_rs1_value = v;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while ((sb.size() != 0 || !bus.req_ready) && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    if (sb.size() != 0 || !bus.req_ready) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    check({tag, "_resp_illegal"}, {31'd0, bus.resp_illegal}, 32'd0);
    check({tag, "_rd"}, bus.resp_rd_value, 32'd0);
    check({tag, "_csr_address"}, {20'd0, bus.csr_address}, 32'd0);
    check({tag, "_wdata"}, bus.csr_write_value, 32'd0);
    check({tag, "_we"}, {31'd0, bus.csr_write_enable}, 32'd0);
  endtask

  task automatic run(input string name, input logic [2:0] f3, input logic [11:0] a,
                     input logic [4:0] fld, input logic [31:0] v, input logic [31:0] rd,
                     input logic ill, input int lat, input int writes,
                     input logic [31:0] wdata);
    issue(f3, a, fld, v, 1'b1, mk(name, rd, ill, lat, writes, wdata, a));
    wait_done();
  endtask

  initial begin
    int t;
    int wr_before;
    for (int i = 0; i < 4096; i++) csr_mem[i] = 32'd0;
    csr_mem[12'h340] = 32'h0000_00F0;
    csr_mem[12'h300] = 32'h0000_1888;
    csr_mem[12'hB00] = 32'h0001_2345;
    csr_mem[12'hF14] = 32'h0000_0000;
    csr_mem[12'hC00] = 32'h0000_ABCD;
    csr_mem[12'h341] = 32'h8000_0000;
    csr_mem[12'h344] = 32'h0000_0080;
    csr_mem[12'h304] = 32'h0000_000F;
    n_cmp = 0; n_fail = 0; total_writes = 0; cyc = 0; wcount = 0; seen = 1'b0;
    bus.req_valid = 1'b0; bus.req_funct3 = 3'd0; bus.req_address = 12'd0;
    bus.req_rs1_field = 5'd0; bus.req_rs1_value = 32'd0; bus.resp_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("reset");
    reset_n = 1'b1;

    run("csrrs_mscratch", 3'b010, 12'h340, 5'd5, 32'h0F, 32'hF0, 1'b0, 3, 1, 32'hFF);
    run("csrrc_mstatus", 3'b011, 12'h300, 5'd3, 32'h8, 32'h1888, 1'b0, 3, 1, 32'h1880);
    check("mstatus_mie", {31'd0, csr_mem[12'h300][3]}, 32'd0);
    run("csrrs_x0_mcycle", 3'b010, 12'hB00, 5'd0, 32'hFFFF, 32'h12345, 1'b0, 2, 0, 32'd0);
    run("csrrwi_mhartid", 3'b101, 12'hF14, 5'd5, 32'd0, 32'd0, 1'b1, 2, 0, 32'd0);
    run("csrrs_x0_mhartid", 3'b010, 12'hF14, 5'd0, 32'd0, 32'd0, 1'b0, 2, 0, 32'd0);
    run("csrrw_cycle_ro", 3'b001, 12'hC00, 5'd7, 32'h5, 32'd0, 1'b1, 2, 0, 32'd0);
    check("cycle_unchanged", csr_mem[12'hC00], 32'h0000_ABCD);
    run("csrrw_mepc", 3'b001, 12'h341, 5'd9, 32'h8000_0100, 32'h8000_0000, 1'b0, 3, 1,
        32'h8000_0100);
    run("csrrsi_mip", 3'b110, 12'h344, 5'h1F, 32'hFFFF_0000, 32'h80, 1'b0, 3, 1, 32'h9F);
    run("csrrci_mie", 3'b111, 12'h304, 5'd3, 32'hFFFF_FFFF, 32'hF, 1'b0, 3, 1, 32'hC);
    run("csrrc_x0_mie", 3'b011, 12'h304, 5'd0, 32'hFFFF_FFFF, 32'hC, 1'b0, 2, 0, 32'd0);

    // Illegal funct3 with the consumer stalling for four cycles.
    bus.resp_ready = 1'b0;
    issue(3'b100, 12'h340, 5'd1, 32'd1, 1'b1,
          mk("funct3_100", 32'd0, 1'b1, 2, 0, 32'd0, 12'h340));
    t = 0;
    while (!bus.resp_valid && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    check("funct3_100_valid", {31'd0, bus.resp_valid}, 32'd1);
    repeat (4) @(posedge clock);
    #1;
    bus.resp_ready = 1'b1;
    wait_done();

    // Reset while in READ for a CSRRW to mepc.
    wr_before = total_writes;
    issue(3'b001, 12'h341, 5'd4, 32'hDEAD_BEEF, 1'b0,
          mk("unused", 32'd0, 1'b0, 0, 0, 32'd0, 12'd0));
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_reset_state("mid_reset");
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("mid_reset_no_write", total_writes, wr_before);
    check("mepc_unchanged", csr_mem[12'h341], 32'h8000_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the machine-mode CSR register file interface.
- Accepts one decoded Zicsr instruction per handshake: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI.
- Sequences the read → modify → write access against the CSR file, which has a combinational read and a posedge write.
- Returns the old CSR value for rd, or an illegal-instruction flag, to the execute stage.

Parameters:
- XLEN, 32, data width. Only 32 is supported.
- ENFORCE_READ_ONLY, 1. When 1, a write attempt to address[11:10]==2'b11 is flagged illegal and suppressed.

Ports:
- clock  input  1  system clock
- reset_n  input  1  synchronous reset, active low
- req_valid  input  1  instruction request valid
- req_ready  output  1  unit idle, can accept a request
- req_funct3  input  3  instruction funct3
- req_address  input  12  CSR address (instr[31:20])
- req_rs1_field  input  5  rs1 index / uimm (instr[19:15])
- req_rs1_value  input  XLEN  rs1 register value
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts result
- resp_rd_value  output  XLEN  old CSR value for rd
- resp_illegal  output  1  raise illegal-instruction exception
- csr_address  output  12  to CSR file address
- csr_read_value  input  XLEN  from CSR file, combinational
- csr_write_value  output  XLEN  to CSR file write data
- csr_write_enable  output  1  to CSR file write strobe

Behaviour:
- Reset (reset_n low at a posedge): state IDLE.
  - req_ready=1; resp_valid=0; resp_illegal=0.
  - resp_rd_value=0; csr_address=0; csr_write_value=0; csr_write_enable=0.
  - Reset mid-operation abandons the access. No write occurs in any cycle after the reset edge.
- FSM states: IDLE, READ, WRITE, RESPOND.
- IDLE:
  - req_ready=1.
  - On req_valid: latch funct3, address, rs1_field and rs1_value; csr_address <= req_address; go to READ.
- READ:
  - csr_address holds the latched address. Capture old = csr_read_value.
  - Operand:
    - funct3[2]=1 → zero-extended rs1_field.
    - funct3[2]=0 → rs1_value.
  - New value by funct3[1:0]:
    - 01 (RW) → operand.
    - 10 (RS) → old | operand.
    - 11 (RC) → old & ~operand.
  - write_intent:
    - 1 for RW/RWI.
    - For RS/RC/RSI/RCI, 1 only if rs1_field != 0. An x0 / zero-uimm set or clear is a pure read.
  - illegal = (funct3[1:0]==2'b00) | (ENFORCE_READ_ONLY & write_intent & address[11:10]==2'b11).
  - Register csr_write_value <= new value and resp_rd_value <= old.
  - Next state:
    - If illegal: resp_rd_value <= 0, resp_illegal <= 1, go to RESPOND.
    - Else if write_intent: go to WRITE.
    - Else: go to RESPOND.
- WRITE:
  - csr_write_enable=1 for exactly this one cycle; the CSR file commits at the end of it.
  - Go to RESPOND.
- RESPOND:
  - resp_valid=1. resp_rd_value and resp_illegal are held stable until resp_ready.
  - On resp_ready: go to IDLE, clearing resp_valid and resp_illegal.
  - No new request is accepted in this state (req_ready=0).
- req_ready=1 only in IDLE. Requests are never accepted back-to-back in consecutive cycles.
- Latency from the acceptance edge (cycle 0):
  - Write access: READ in cycle 1, WRITE in cycle 2, resp_valid in cycle 3.
  - Pure read or illegal access: resp_valid in cycle 2.
- csr_write_enable is never asserted outside WRITE. It is never asserted for an illegal instruction.
- Read-modify-write is atomic with respect to this unit: no other CSR writer is active between READ and WRITE.
- csr_address is stable from READ through WRITE.

Test Plan:
- mscratch (0x340) holds 0x0000_00F0; CSRRS with rs1_value=0x0F, rs1_field=5 → one write of 0x0000_00FF; resp_rd_value=0xF0; resp_valid in cycle 3.
- CSRRC on mstatus (0x300) holding 0x0000_1888, rs1_value=0x8 → write 0x0000_1880; rd=0x1888; mstatus MIE reads 0.
- CSRRS with rs1_field=0 on mcycle (0xB00) → csr_write_enable never asserted; rd=current mcycle; resp_valid in cycle 2.
- CSRRWI uimm=5 on mhartid (0xF14) → resp_illegal=1, rd=0, no write strobe. Repeat with CSRRS, rs1_field=0 → legal, rd=0.
- funct3=3'b100 → resp_illegal=1, no write. Hold resp_ready=0 for 4 cycles → outputs stable, req_ready=0 throughout.
- Assert reset_n=0 in the cycle the FSM is in READ for a CSRRW to 0x341 → no write strobe; all outputs at reset values; mepc unchanged.
